// File: rtl/modport_bus_if.sv
// CPU-side memory access point: routes each access to the scratch-pad memory or
// to the shared system bus, running the request/grant/access/ready handshake.
module modport_bus_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int IDX_HI = 29,
  parameter int IDX_LO = 27,
  parameter logic [IDX_HI-IDX_LO:0] SPM_INDEX = 3'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  output logic              busy,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_as_n,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_n,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic              bus_req_n,
  input  logic              bus_grnt_n,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_n,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_n
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] rd_buf;
  logic              cpu_valid;
  logic              is_spm;

  assign cpu_valid   = !cpu_as_n && !flush;
  assign is_spm      = (cpu_addr[IDX_HI:IDX_LO] == SPM_INDEX);
  assign spm_addr    = cpu_addr;
  assign spm_rw      = cpu_rw;
  assign spm_wr_data = cpu_wr_data;

  // Next-state decode and the combinational CPU/SPM-side responses.
  always_comb begin
    next_state  = state;
    cpu_rd_data = '0;
    spm_as_n    = 1'b1;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_valid && is_spm) begin
          if (!stall) begin
            spm_as_n = 1'b0;
            if (cpu_rw) begin
              cpu_rd_data = spm_rd_data;
            end else begin
              cpu_rd_data = '0;
            end
          end else begin
            spm_as_n = 1'b1;
          end
        end else if (cpu_valid) begin
          busy       = 1'b1;
          next_state = REQ;
        end else begin
          busy = 1'b0;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (!bus_grnt_n) begin
          next_state = ACCESS;
        end else begin
          next_state = REQ;
        end
      end
      ACCESS: begin
        if (!bus_rdy_n) begin
          busy       = 1'b0;
          next_state = stall ? STALL : IDLE;
          if (cpu_rw) begin
            cpu_rd_data = bus_rd_data;
          end else begin
            cpu_rd_data = '0;
          end
        end else begin
          busy = 1'b1;
        end
      end
      STALL: begin
        if (cpu_rw) begin
          cpu_rd_data = rd_buf;
        end else begin
          cpu_rd_data = '0;
        end
        if (!stall) begin
          next_state = IDLE;
        end else begin
          next_state = STALL;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register plus the registered bus command; the strobe is one cycle wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bus_req_n   <= 1'b1;
      bus_as_n    <= 1'b1;
      bus_addr    <= '0;
      bus_rw      <= 1'b1;
      bus_wr_data <= '0;
      rd_buf      <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (cpu_valid && !is_spm) begin
            bus_addr    <= cpu_addr;
            bus_rw      <= cpu_rw;
            bus_wr_data <= cpu_wr_data;
            bus_req_n   <= 1'b0;
          end
        end
        REQ: begin
          if (!bus_grnt_n) begin
            bus_as_n <= 1'b0;
          end
        end
        ACCESS: begin
          bus_as_n <= 1'b1;
          if (!bus_rdy_n) begin
            bus_req_n   <= 1'b1;
            bus_addr    <= '0;
            bus_rw      <= 1'b1;
            bus_wr_data <= '0;
            if (bus_rw) begin
              rd_buf <= bus_rd_data;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modport_bus_if.sv
// Self-checking bench: single-cycle vector table, directed bus sequences and
// randomized transactions checked against a per-transaction timeline model.
module tb_modport_bus_if;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        busy;
  logic [29:0] cpu_addr;
  logic        cpu_as_n;
  logic        cpu_rw;
  logic [31:0] cpu_wr_data;
  logic [31:0] cpu_rd_data;
  logic [29:0] spm_addr;
  logic        spm_as_n;
  logic        spm_rw;
  logic [31:0] spm_wr_data;
  logic [31:0] spm_rd_data;
  logic        bus_req_n;
  logic        bus_grnt_n;
  logic [29:0] bus_addr;
  logic        bus_as_n;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_n;

  int checks = 0;
  int failures = 0;

  modport_bus_if dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .busy(busy),
    .cpu_addr(cpu_addr), .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
    .spm_addr(spm_addr), .spm_as_n(spm_as_n), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
    .bus_req_n(bus_req_n), .bus_grnt_n(bus_grnt_n), .bus_addr(bus_addr),
    .bus_as_n(bus_as_n), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_n(bus_rdy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        as_n;
    logic        flush;
    logic        stall;
    logic [2:0]  idx;
    logic        rw;
    logic [31:0] spm_d;
    logic        e_spm_as_n;
    logic [31:0] e_rd;
    logic        e_busy;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    cpu_as_n    = 1'b1;
    cpu_addr    = 30'd0;
    cpu_rw      = 1'b1;
    cpu_wr_data = 32'd0;
    flush       = 1'b0;
    stall       = 1'b0;
    bus_grnt_n  = 1'b1;
    bus_rdy_n   = 1'b1;
    bus_rd_data = 32'd0;
    spm_rd_data = 32'd0;
  endtask

  // One bus transaction: request in cycle 0, grant in cycle g, ready in cycle r.
  // Expected waveforms follow directly from the handshake timeline.
  task automatic run_bus(input logic [2:0] idx, input logic rw, input logic [31:0] wdata,
                         input int g, input int r, input logic stl, input int slen);
    logic [29:0] addr;
    logic [31:0] rdat;
    logic        in_cmd;
    addr = {idx, 27'($urandom)};
    rdat = $urandom;
    for (int c = 0; c <= r + 1; c++) begin
      @(posedge clk); #1;
      cpu_as_n    = (c <= r) ? 1'b0 : 1'b1;
      cpu_addr    = addr;
      cpu_rw      = rw;
      cpu_wr_data = wdata;
      flush       = 1'b0;
      bus_grnt_n  = (c == g) ? 1'b0 : 1'b1;
      bus_rdy_n   = (c == r) ? 1'b0 : 1'b1;
      bus_rd_data = (c == r) ? rdat : $urandom;
      if (c < r) stall = 1'($urandom);
      else       stall = stl;
      #1;
      in_cmd = (c >= 1) && (c <= r);
      chk("bus_busy", 32'(busy), 32'(c < r));
      chk("bus_req_n", 32'(bus_req_n), 32'(!in_cmd));
      chk("bus_as_n", 32'(bus_as_n), 32'(c != g + 1));
      chk("bus_addr", 32'(bus_addr), in_cmd ? 32'(addr) : 32'd0);
      chk("bus_rw", 32'(bus_rw), in_cmd ? 32'(rw) : 32'd1);
      chk("bus_wr_data", bus_wr_data, in_cmd ? wdata : 32'd0);
      chk("bus_rd_data_out", cpu_rd_data,
          (rw && (c == r || (c == r + 1 && stl))) ? rdat : 32'd0);
    end
    if (stl) begin
      for (int k = 0; k < slen; k++) begin
        @(posedge clk); #1;
        stall       = (k < slen - 1) ? 1'b1 : 1'b0;
        bus_rd_data = $urandom;
        #1;
        chk("stall_rd_buf", cpu_rd_data, rw ? rdat : 32'd0);
        chk("stall_busy", 32'(busy), 32'd0);
      end
      @(posedge clk); #1;
      #1;
      chk("stall_exit_rd", cpu_rd_data, 32'd0);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Single-cycle scratch-pad access with random data and stall.
  task automatic run_spm();
    logic [31:0] d;
    logic        rw;
    logic        st;
    d  = $urandom;
    rw = 1'($urandom);
    st = 1'($urandom);
    @(posedge clk); #1;
    cpu_as_n    = 1'b0;
    cpu_addr    = {3'd1, 27'($urandom)};
    cpu_rw      = rw;
    cpu_wr_data = $urandom;
    stall       = st;
    spm_rd_data = d;
    #1;
    chk("spm_as_n", 32'(spm_as_n), 32'(st));
    chk("spm_rd", cpu_rd_data, (!st && rw) ? d : 32'd0);
    chk("spm_busy", 32'(busy), 32'd0);
    chk("spm_addr", 32'(spm_addr), 32'(cpu_addr));
    chk("spm_wr_data", spm_wr_data, cpu_wr_data);
    chk("spm_rw", 32'(spm_rw), 32'(rw));
  endtask

  function automatic logic [2:0] bus_idx();
    logic [2:0] i;
    i = 3'($urandom_range(2, 8));
    return i;
  endfunction

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 32'hCAFE0001, 1'b0, 32'hCAFE0001, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'hCAFE0001, 1'b1, 32'h00000000, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 32'h11111111, 1'b1, 32'h00000000, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 32'h22222222, 1'b1, 32'h00000000, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 32'h33333333, 1'b1, 32'h00000000, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 32'h44444444, 1'b1, 32'h00000000, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 32'h55555555, 1'b1, 32'h00000000, 1'b0};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_bus_req_n", 32'(bus_req_n), 32'd1);
    chk("rst_bus_as_n", 32'(bus_as_n), 32'd1);
    chk("rst_bus_addr", 32'(bus_addr), 32'd0);
    chk("rst_bus_rw", 32'(bus_rw), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cpu_rd_data", cpu_rd_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      cpu_as_n    = vecs[i].as_n;
      flush       = vecs[i].flush;
      stall       = vecs[i].stall;
      cpu_addr    = {vecs[i].idx, 27'h0000123};
      cpu_rw      = vecs[i].rw;
      spm_rd_data = vecs[i].spm_d;
      #1;
      chk("vec_spm_as_n", 32'(spm_as_n), 32'(vecs[i].e_spm_as_n));
      chk("vec_rd", cpu_rd_data, vecs[i].e_rd);
      chk("vec_busy", 32'(busy), 32'(vecs[i].e_busy));
      @(posedge clk); #1;
      chk("vec_req_stays_1", 32'(bus_req_n), 32'd1);
      idle_inputs();
    end

    // Read: grant two cycles after the request, ready one cycle after the strobe.
    run_bus(3'd2, 1'b1, 32'd0, 2, 4, 1'b0, 0);
    // Write with minimum latency.
    run_bus(3'd3, 1'b0, 32'hA5A5A5A5, 1, 2, 1'b0, 0);
    // Stall at completion, held for three cycles.
    run_bus(3'd4, 1'b1, 32'd0, 1, 3, 1'b1, 3);
    // Late ready on a write, stalled at completion.
    run_bus(3'd0, 1'b0, 32'h0F0F0F0F, 3, 7, 1'b1, 1);

    // Reset mid-transaction while in the access phase.
    @(posedge clk); #1;
    cpu_as_n = 1'b0;
    cpu_addr = {3'd6, 27'h0000055};
    cpu_rw   = 1'b1;
    @(posedge clk); #1;
    bus_grnt_n = 1'b0;
    @(posedge clk); #1;
    bus_grnt_n = 1'b1;
    #1;
    chk("pre_rst_as_n", 32'(bus_as_n), 32'd0);
    chk("pre_rst_req_n", 32'(bus_req_n), 32'd0);
    rst = 1'b1;
    cpu_as_n = 1'b1;
    #1;
    chk("mid_rst_req_n", 32'(bus_req_n), 32'd1);
    chk("mid_rst_as_n", 32'(bus_as_n), 32'd1);
    chk("mid_rst_addr", 32'(bus_addr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();

    for (int n = 0; n < 60; n++) begin
      int kind;
      int g;
      int r;
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        run_spm();
      end else if (kind == 1) begin
        @(posedge clk); #1;
        cpu_as_n = 1'b0;
        flush    = 1'b1;
        stall    = 1'($urandom);
        cpu_addr = {bus_idx(), 27'($urandom)};
        cpu_rw   = 1'($urandom);
        #1;
        chk("flush_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("flush_req_n", 32'(bus_req_n), 32'd1);
        idle_inputs();
      end else begin
        g = $urandom_range(1, 4);
        r = g + $urandom_range(1, 4);
        run_bus(bus_idx(), 1'($urandom), $urandom, g, r, 1'($urandom),
                $urandom_range(1, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
